// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed common-anode seven-segment driver.
// A prescaler paces the digit scan. Loads land in a staging buffer and are
// promoted to the display buffer only when the scan wraps, so a frame is never
// drawn from a half-updated value. Segment, dp and anode outputs are registered
// and lag the scan index by one cycle.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int HEX_MODE    = 1,
    parameter int LZ_BLANK    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic [6:0]                segment_n,
    output logic                      dp_n,
    output logic [NUM_DIGITS-1:0]     anode_n,
    output logic                      pending,
    output logic                      frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam int PS_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PS_W-1:0]  LAST_PS  = PS_W'(REFRESH_DIV - 1);

    logic [PS_W-1:0]         prescale_reg;
    logic [IDX_W-1:0]        index_reg;
    logic                    frame_done_reg;
    logic [4*NUM_DIGITS-1:0] staging_value_reg;
    logic [NUM_DIGITS-1:0]   staging_dp_reg;
    logic [4*NUM_DIGITS-1:0] display_value_reg;
    logic [NUM_DIGITS-1:0]   display_dp_reg;
    logic                    pending_reg;

    logic [6:0]              segment_reg;
    logic                    dp_reg;
    logic [NUM_DIGITS-1:0]   anode_reg;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              nibble [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   anode_next;
    logic [3:0]              cur_nibble;
    logic [6:0]              glyph;
    logic [6:0]              segment_next;
    logic                    dp_next;

    assign tick = (prescale_reg == LAST_PS);
    assign wrap = tick && (index_reg == LAST_IDX);

    // Scan timing: prescaler, digit index and the frame-boundary pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_reg   <= '0;
            index_reg      <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            prescale_reg   <= tick ? '0 : prescale_reg + PS_W'(1);
            if (tick) begin
                index_reg <= (index_reg == LAST_IDX) ? '0 : index_reg + IDX_W'(1);
            end
            frame_done_reg <= wrap;
        end
    end

    // Double buffer: loads go to staging; promotion happens only at a wrap,
    // using the pending flag as it stood before this cycle's load.
    always_ff @(posedge clk) begin
        if (rst) begin
            staging_value_reg <= '0;
            staging_dp_reg    <= '0;
            display_value_reg <= '0;
            display_dp_reg    <= '0;
            pending_reg       <= 1'b0;
        end else begin
            if (wrap && pending_reg) begin
                display_value_reg <= staging_value_reg;
                display_dp_reg    <= staging_dp_reg;
            end
            if (load) begin
                staging_value_reg <= value_in;
                staging_dp_reg    <= dp_in;
                pending_reg       <= 1'b1;
            end else if (wrap) begin
                pending_reg <= 1'b0;
            end
        end
    end

    // Per-digit nibble split, leading-zero mask and one-cold anode pattern.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nibble[gi]     = display_value_reg[4*gi +: 4];
            assign anode_next[gi] = (index_reg != IDX_W'(gi));
            if (gi == 0 || LZ_BLANK == 0) begin : g_noblank
                assign blank[gi] = 1'b0;
            end else begin : g_lzb
                assign blank[gi] = (display_value_reg[4*NUM_DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    // Glyph lookup for the digit under the scan index.
    always_comb begin
        glyph      = 7'b111_1111;
        cur_nibble = nibble[index_reg];
        case (cur_nibble)
            4'h0: glyph = 7'b100_0000;
            4'h1: glyph = 7'b111_1001;
            4'h2: glyph = 7'b010_0100;
            4'h3: glyph = 7'b011_0000;
            4'h4: glyph = 7'b001_1001;
            4'h5: glyph = 7'b001_0010;
            4'h6: glyph = 7'b000_0010;
            4'h7: glyph = 7'b111_1000;
            4'h8: glyph = 7'b000_0000;
            4'h9: glyph = 7'b001_0000;
            4'hA: glyph = (HEX_MODE != 0) ? 7'b000_1000 : 7'b111_1111;
            4'hB: glyph = (HEX_MODE != 0) ? 7'b000_0011 : 7'b111_1111;
            4'hC: glyph = (HEX_MODE != 0) ? 7'b100_0110 : 7'b111_1111;
            4'hD: glyph = (HEX_MODE != 0) ? 7'b010_0001 : 7'b111_1111;
            4'hE: glyph = (HEX_MODE != 0) ? 7'b000_0110 : 7'b111_1111;
            default: glyph = (HEX_MODE != 0) ? 7'b000_1110 : 7'b111_1111;
        endcase
        segment_next = blank[index_reg] ? 7'b111_1111 : glyph;
        dp_next      = ~display_dp_reg[index_reg];
    end

    // Registered pin drivers; blanking never suppresses the decimal point.
    always_ff @(posedge clk) begin
        if (rst) begin
            segment_reg <= 7'b111_1111;
            dp_reg      <= 1'b1;
            anode_reg   <= '1;
        end else begin
            segment_reg <= segment_next;
            dp_reg      <= dp_next;
            anode_reg   <= anode_next;
        end
    end

    assign segment_n  = segment_reg;
    assign dp_n       = dp_reg;
    assign anode_n    = anode_reg;
    assign pending    = pending_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: two instances (hex+blanking, decimal-only
// without blanking) share stimulus; a cycle-count based model predicts every
// output each cycle, and directed steps pin literal glyphs and timing.
module tb_seven_seg_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  an_a, an_b;
    logic        pend_a, pend_b, fd_a, fd_b;

    int total = 0;
    int bad   = 0;
    bit armed = 0;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .HEX_MODE(1), .LZ_BLANK(1)) dut_a (
        .clk(clk), .rst(rst), .load(load), .value_in(value_in), .dp_in(dp_in),
        .segment_n(seg_a), .dp_n(dp_a), .anode_n(an_a), .pending(pend_a), .frame_done(fd_a));

    seven_seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .HEX_MODE(0), .LZ_BLANK(0)) dut_b (
        .clk(clk), .rst(rst), .load(load), .value_in(value_in), .dp_in(dp_in),
        .segment_n(seg_b), .dp_n(dp_b), .anode_n(an_b), .pending(pend_b), .frame_done(fd_b));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int v, input bit hex);
        case (v)
            0: return 7'b100_0000;
            1: return 7'b111_1001;
            2: return 7'b010_0100;
            3: return 7'b011_0000;
            4: return 7'b001_1001;
            5: return 7'b001_0010;
            6: return 7'b000_0010;
            7: return 7'b111_1000;
            8: return 7'b000_0000;
            9: return 7'b001_0000;
            10: return hex ? 7'b000_1000 : 7'b111_1111;
            11: return hex ? 7'b000_0011 : 7'b111_1111;
            12: return hex ? 7'b100_0110 : 7'b111_1111;
            13: return hex ? 7'b010_0001 : 7'b111_1111;
            14: return hex ? 7'b000_0110 : 7'b111_1111;
            default: return hex ? 7'b000_1110 : 7'b111_1111;
        endcase
    endfunction

    // Digit idx is blank when the value shifted down to idx is zero and idx > 0.
    function automatic logic [6:0] exp_seg(input logic [15:0] disp, input int idx, input bit hex, input bit lz);
        logic [15:0] upper;
        upper = disp >> (4 * idx);
        if (lz && idx > 0 && upper == 16'h0) return 7'b111_1111;
        return glyph(int'(upper[3:0]), hex);
    endfunction

    // Model: scan position derived purely from cycles elapsed since reset.
    int          m_t = 0;
    int          m_idx;
    logic        m_wrap;
    logic [15:0] m_stage = '0, m_disp = '0;
    logic [3:0]  m_sdp = '0, m_ddp = '0;
    logic        m_pend = 0, m_fd = 0;
    logic [6:0]  e_seg_a = 7'h7f, e_seg_b = 7'h7f;
    logic        e_dp = 1'b1;
    logic [3:0]  e_an = 4'hf;

    assign m_idx  = (m_t / DIV) % N;
    assign m_wrap = ((m_t + 1) % (N * DIV)) == 0;

    // Model state advance.
    always @(posedge clk) begin
        if (rst) begin
            m_t <= 0; m_stage <= '0; m_sdp <= '0; m_disp <= '0; m_ddp <= '0;
            m_pend <= 1'b0; m_fd <= 1'b0;
            e_an <= 4'hf; e_seg_a <= 7'h7f; e_seg_b <= 7'h7f; e_dp <= 1'b1;
        end else begin
            m_t     <= m_t + 1;
            m_fd    <= m_wrap;
            e_an    <= ~(4'b0001 << m_idx);
            e_seg_a <= exp_seg(m_disp, m_idx, 1'b1, 1'b1);
            e_seg_b <= exp_seg(m_disp, m_idx, 1'b0, 1'b0);
            e_dp    <= ~m_ddp[m_idx];
            if (m_wrap && m_pend) begin
                m_disp <= m_stage;
                m_ddp  <= m_sdp;
            end
            if (load) begin
                m_stage <= value_in;
                m_sdp   <= dp_in;
                m_pend  <= 1'b1;
            end else if (m_wrap) begin
                m_pend <= 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            check("seg_a", seg_a, e_seg_a);
            check("seg_b", seg_b, e_seg_b);
            check("anode_a", an_a, e_an);
            check("anode_b", an_b, e_an);
            check("dp_a", dp_a, e_dp);
            check("dp_b", dp_b, e_dp);
            check("pending_a", pend_a, m_pend);
            check("pending_b", pend_b, m_pend);
            check("frame_done_a", fd_a, m_fd);
            check("frame_done_b", fd_b, m_fd);
        end
    end

    task automatic wait_fd();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fd_a) return;
        end
        check("frame_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic show(input int d, input logic [6:0] ea, input logic [6:0] eb);
        logic [3:0] tgt;
        tgt = ~(4'b0001 << d);
        for (int i = 0; i < 40; i++) begin
            if (an_a == tgt) begin
                check($sformatf("glyph_a_d%0d", d), seg_a, ea);
                check($sformatf("glyph_b_d%0d", d), seg_b, eb);
                return;
            end
            @(negedge clk);
        end
        check("anode_timeout", 32'd0, 32'd1);
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] dp);
        @(negedge clk);
        load = 1'b1; value_in = v; dp_in = dp;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int n;
        int lit_ok;
        int lit_bad;
        logic [15:0] r;

        // Reset and release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        armed = 1'b1;
        check("rst_anode", an_a, 32'hf);
        check("rst_seg", seg_a, 32'h7f);
        @(negedge clk);
        check("rel_anode", an_a, 32'b1110);
        check("rel_seg", seg_a, 32'b100_0000);
        check("rel_dp", dp_a, 32'd1);

        // Frame period.
        wait_fd();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (fd_a) break;
        end
        check("frame_period", n, 32'd16);

        // 1234 mid-frame: pending, then glyphs after wrap.
        $display("txn load 1234");
        load_val(16'h1234, 4'b0000);
        check("pend_after_load", pend_a, 32'd1);
        wait_fd();
        show(0, 7'b001_1001, 7'b001_1001);
        show(1, 7'b011_0000, 7'b011_0000);
        show(2, 7'b010_0100, 7'b010_0100);
        show(3, 7'b111_1001, 7'b111_1001);
        check("pend_cleared", pend_a, 32'd0);

        $display("txn load 0050");
        load_val(16'h0050, 4'b0000);
        wait_fd();
        show(0, 7'b100_0000, 7'b100_0000);
        show(1, 7'b001_0010, 7'b001_0010);
        show(2, 7'b111_1111, 7'b100_0000);
        show(3, 7'b111_1111, 7'b100_0000);

        $display("txn load ABCF");
        load_val(16'hABCF, 4'b0000);
        wait_fd();
        show(0, 7'b000_1110, 7'b111_1111);
        show(1, 7'b100_0110, 7'b111_1111);
        show(2, 7'b000_0011, 7'b111_1111);
        show(3, 7'b000_1000, 7'b111_1111);

        // Last load wins; load on the wrap cycle is deferred one frame.
        $display("txn load 1111/2222 then 3333 on wrap");
        wait_fd();
        load_val(16'h1111, 4'b0000);
        load_val(16'h2222, 4'b0000);
        for (int i = 0; i < 40 && !m_wrap; i++) @(negedge clk);
        load = 1'b1; value_in = 16'h3333;
        @(negedge clk);
        load = 1'b0;
        check("pend_wrap_load", pend_a, 32'd1);
        show(0, 7'b010_0100, 7'b010_0100);
        check("pend_still", pend_a, 32'd1);
        wait_fd();
        show(0, 7'b011_0000, 7'b011_0000);
        check("pend_done", pend_a, 32'd0);

        // Decimal point on a blanked digit.
        $display("txn dp 0100 value 0");
        load_val(16'h0000, 4'b0100);
        wait_fd();
        lit_ok = 0; lit_bad = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!dp_a && an_a == 4'b1011) lit_ok++;
            if (!dp_a && an_a != 4'b1011) lit_bad++;
            if (an_a == 4'b1011) check("blank_d2", seg_a, 32'h7f);
        end
        check("dp_lit_cycles", lit_ok, 32'd4);
        check("dp_wrong_digit", lit_bad, 32'd0);

        // Reset mid-frame.
        $display("txn reset mid-frame");
        load_val(16'h9876, 4'b1111);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_anode", an_a, 32'hf);
        check("mid_rst_seg", seg_a, 32'h7f);
        check("mid_rst_dp", dp_a, 32'd1);
        check("mid_rst_pend", pend_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_anode", an_a, 32'b1110);
        check("post_rst_seg", seg_a, 32'b100_0000);

        // Randomised traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            load = 1'b0;
            rst = 1'b0;
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                $display("txn random reset");
            end else if ($urandom_range(0, 9) == 0) begin
                r = 16'($urandom);
                value_in = r >> (4 * $urandom_range(0, 4));
                dp_in = 4'($urandom);
                load = 1'b1;
                $display("txn load %h dp %b", value_in, dp_in);
            end
        end
        @(negedge clk);
        load = 1'b0;
        rst = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
